// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, ALU/mux selects,
// state numbering and trap codes.
package mips_ctrl_pkg;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] ADDI   = 6'b001000;
  localparam logic [5:0] ANDI   = 6'b001100;
  localparam logic [5:0] ORI    = 6'b001101;
  localparam logic [5:0] SLTI   = 6'b001010;
  localparam logic [5:0] J      = 6'b000010;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  // ALU operation for the immediate-arithmetic group; opcode is held through IWB.
  function automatic logic [3:0] imm_aluop(input logic [5:0] op);
    case (op)
      ANDI:    return ALU_AND;
      ORI:     return ALU_OR;
      SLTI:    return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle. Handshake: the memory raises mem_ready in the cycle a
// MemRead/MemWrite request completes; the controller holds its request until it sees it.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUop;
  logic [1:0] PCSource;
  logic       instr_done;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, instr_done
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, instr_done
  );
endinterface

// File: rtl/mips_multicycle_ctrl_timer.sv
// Counts consecutive cycles spent waiting on memory; expired flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TW          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        count <= '0;
    else if (clear)    count <= '0;
    else if (count_en) count <= count + 1'b1;
  end

  assign expired = (count == TW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with memory-wait timeout and sticky trap.
// Define MIPS_JUMP_EN to decode opcode 000010 (j) into the JUMP state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TW          = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus,
  output logic [1:0]             trap,
  output logic [3:0]             state
);

  state_t     cur, nxt;
  logic [1:0] trap_q, trap_nxt;
  logic       waiting, expired;
  ctrl_t      o;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur    <= S_RST;
      trap_q <= TRAP_NONE;
    end else begin
      cur    <= nxt;
      trap_q <= trap_nxt;
    end
  end

  always_comb begin
    nxt      = cur;
    trap_nxt = trap_q;
    case (cur)
      S_RST:    nxt = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) nxt = S_DECODE;
        else if (expired) begin nxt = S_TRAP; trap_nxt = TRAP_TIMEOUT; end
      end
      S_DECODE: begin
        case (bus.opcode)
          LW, SW:                 nxt = S_MEMADR;
          R_TYPE:                 nxt = S_REXEC;
          BEQ:                    nxt = S_BRANCH;
          ADDI, ANDI, ORI, SLTI:  nxt = S_IEXEC;
`ifdef MIPS_JUMP_EN
          J:                      nxt = S_JUMP;
`endif
          default: begin nxt = S_TRAP; trap_nxt = TRAP_ILLEGAL; end
        endcase
      end
      S_MEMADR: nxt = (bus.opcode == LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready) nxt = S_MEMWB;
        else if (expired) begin nxt = S_TRAP; trap_nxt = TRAP_TIMEOUT; end
      end
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR: begin
        if (bus.mem_ready) nxt = S_FETCH;
        else if (expired) begin nxt = S_TRAP; trap_nxt = TRAP_TIMEOUT; end
      end
      S_REXEC:  nxt = S_RWB;
      S_RWB:    nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_IEXEC:  nxt = S_IWB;
      S_IWB:    nxt = S_FETCH;
`ifdef MIPS_JUMP_EN
      S_JUMP:   nxt = S_FETCH;
`endif
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_RST;
    endcase
  end

  // The counter restarts on any state change so each memory access gets its own budget.
  assign waiting = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .count_en (waiting && !bus.mem_ready),
    .clear    (bus.mem_ready || (nxt != cur)),
    .expired  (expired)
  );

  always_comb begin
    o = '0;
    case (cur)
      S_FETCH: begin
        o.mem_read = 1'b1;
        if (bus.mem_ready) begin
          o.ir_write  = 1'b1;
          o.pc_write  = 1'b1;
          o.alu_src_b = SRCB_FOUR;
          o.alu_op    = ALU_ADD;
          o.pc_source = PCSRC_ALU;
        end
      end
      S_DECODE: begin o.alu_src_b = SRCB_IMM_SH2; o.alu_op = ALU_ADD; end
      S_MEMADR: begin o.alu_src_a = 1'b1; o.alu_src_b = SRCB_IMM; o.alu_op = ALU_ADD; end
      S_MEMRD:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
      S_MEMWB:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1; end
      S_MEMWR: begin
        o.mem_write  = 1'b1;
        o.i_or_d     = 1'b1;
        o.instr_done = bus.mem_ready;
      end
      S_REXEC:  begin o.alu_src_a = 1'b1; o.alu_src_b = SRCB_RT; o.alu_op = ALU_FUNCT; end
      S_RWB:    begin o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1; end
      S_BRANCH: begin
        o.alu_src_a     = 1'b1;
        o.alu_src_b     = SRCB_RT;
        o.alu_op        = ALU_SUB;
        o.pc_write_cond = 1'b1;
        o.pc_source     = PCSRC_ALUOUT;
        o.instr_done    = 1'b1;
      end
      S_IEXEC: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = SRCB_IMM;
        o.alu_op    = imm_aluop(bus.opcode);
      end
      S_IWB: begin
        o.alu_src_a  = 1'b1;
        o.alu_src_b  = SRCB_IMM;
        o.alu_op     = imm_aluop(bus.opcode);
        o.reg_write  = 1'b1;
        o.instr_done = 1'b1;
      end
`ifdef MIPS_JUMP_EN
      S_JUMP:   begin o.pc_write = 1'b1; o.pc_source = PCSRC_JUMP; o.instr_done = 1'b1; end
`endif
      default:  o = '0;
    endcase
  end

  assign bus.PCWrite     = o.pc_write;
  assign bus.PCWriteCond = o.pc_write_cond;
  assign bus.IorD        = o.i_or_d;
  assign bus.MemRead     = o.mem_read;
  assign bus.MemWrite    = o.mem_write;
  assign bus.IRWrite     = o.ir_write;
  assign bus.MemtoReg    = o.mem_to_reg;
  assign bus.RegDst      = o.reg_dst;
  assign bus.RegWrite    = o.reg_write;
  assign bus.ALUSrcA     = o.alu_src_a;
  assign bus.ALUSrcB     = o.alu_src_b;
  assign bus.ALUop       = o.alu_op;
  assign bus.PCSource    = o.pc_source;
  assign bus.instr_done  = o.instr_done;
  assign trap            = trap_q;
  assign state           = cur;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Supports the same instruction set as the single-cycle control unit: R-type, lw, sw, beq, addi, andi, ori, slti.
- Adds a memory ready handshake with a wait timeout, and a sticky trap on illegal opcode or timeout.
- Sits between the instruction register (opcode source) and the datapath mux/enable controls.

Parameters:
- MEM_TIMEOUT, 16: max consecutive cycles spent waiting for mem_ready before a trap (valid range 1..255).
- TW, 8: width of the wait counter; must satisfy 2^TW > MEM_TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- opcode  in  6  IR[31:26]; stable from DECODE until the next fetch completes.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load when ALU zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data select: 1 = MDR.
- RegDst  out  1  destination register select: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = 4, 10 = signext imm, 11 = signext imm << 2.
- ALUop  out  4  0000 add, 0001 sub, 0010 funct, 0011 and, 0100 or, 0101 slt.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- trap  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout; sticky until reset.
- state  out  4  current state (debug).

Behaviour:
- States: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REXEC=7, RWB=8, BRANCH=9, IEXEC=10, IWB=11, JUMP=12, TRAP=13.
- Reset asserted: state=RST, wait counter=0, trap=00. In RST every output is 0.
- RST always goes to FETCH on the next clock edge.
- Outputs are decoded from the state combinationally; only FETCH, MEMRD and MEMWR additionally depend on mem_ready. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0.
  - When mem_ready=1 in the same cycle: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUop=0000, PCSource=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=0000 (branch target into ALUOut). Next state by opcode:
  - lw or sw -> MEMADR.
  - R-type -> REXEC.
  - beq -> BRANCH.
  - addi/andi/ori/slti -> IEXEC.
  - anything else -> TRAP with trap=01.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=0000. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Goes to MEMWB when mem_ready=1.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1; then FETCH.
- MEMWR: MemWrite=1, IorD=1. When mem_ready=1: instr_done=1, then FETCH.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUop=0010; then RWB.
- RWB: RegDst=1, RegWrite=1, instr_done=1; then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=0001, PCWriteCond=1, PCSource=01, instr_done=1; then FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10. ALUop is addi 0000, andi 0011, ori 0100, slti 0101. Then IWB.
- IWB: RegDst=0, RegWrite=1, MemtoReg=0, instr_done=1, ALUSrcA/ALUSrcB/ALUop held at their IEXEC values; then FETCH.
- Cycles per instruction with zero memory wait: lw 5, sw 4, R-type 4, I-type 4, beq 3.
- Wait counter:
  - Increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - Clears on every state change and whenever mem_ready=1.
  - When the counter equals MEM_TIMEOUT-1 and mem_ready is still 0, the next state is TRAP with trap=10.
  - mem_ready=1 in that same cycle wins: normal transition, no trap.
- TRAP: all outputs 0, state held, trap code held. Only reset exits TRAP.
- Reset asserted mid-instruction: immediate return to RST, all outputs 0 asynchronously; no partial writes are emitted afterwards.
- MemRead and MemWrite are never both 1. RegWrite and any PC write are never both 1.

Optional Feature:
- MIPS_JUMP_EN.
  - Defined: opcode 000010 (j) in DECODE goes to JUMP. JUMP asserts PCWrite=1, PCSource=10, instr_done=1, then FETCH (3 cycles total).
  - Undefined: opcode 000010 is illegal (TRAP, trap=01); state 12 is unreachable and PCSource never drives 10.

Decomposition:
- Package mips_ctrl_pkg:
  - opcode constants (R_TYPE, LW, SW, BEQ, ADDI, ANDI, ORI, SLTI, J);
  - ALUop codes; state encodings; ALUSrcB and PCSource select codes; trap codes.
- Sub-module mem_wait_timer(clk, reset, count_en, clear, expired), parameterised by MEM_TIMEOUT and TW; the FSM instantiates it once.

Test Plan:
- Release reset, mem_ready tied 1, opcode=000000 -> state sequence 0,1,2,7,8,1. instr_done pulses in RWB. RegDst=1, RegWrite=1 in RWB. ALUop=0010 in REXEC.
- lw (100011) with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with MemtoReg=1, RegWrite=1. No trap.
- MEM_TIMEOUT=4, mem_ready held 0 from reset -> 4 cycles in FETCH, then TRAP with trap=10 and all outputs 0. Toggling mem_ready afterwards has no effect until reset.
- opcode=111111 -> DECODE goes to TRAP, trap=01. opcode=000010 gives trap=01 without MIPS_JUMP_EN, and a JUMP with PCSource=10 and PCWrite=1 with it.
- slti (001010) then beq (000100) back-to-back -> IEXEC ALUop=0101, ALUSrcB=10. BRANCH: PCWriteCond=1, PCSource=01, ALUop=0001. Exactly 2 instr_done pulses in 7 cycles.
- Reset asserted during MEMWR with MemWrite=1 -> MemWrite drops to 0 the same cycle; after release, the FSM restarts from RST then FETCH.
